msk_inv_mixcolumn_pipe: RTL and testbench

Masked InvMixColumns unit for the decryption datapath. Takes one d-share masked AES column (4 bytes) per cycle through a valid/ready handshake and returns InvMixColumns of it, computed sharewise, so no randomness is consumed. It is the inverse-direction counterpart of the encryption MixColumns product logic and sits between the inverse S-box/ShiftRows stage and AddRoundKey. A bypass sideband passes columns through unchanged for the final decryption round.

---
 rtl/msk_aes_pkg.sv | 17 +
 rtl/msk_inv_mixcolumn_pipe_if.sv | 18 +
 rtl/msk_xtime_sharewise.sv | 17 +
 rtl/msk_inv_mixcolumn_pipe.sv | 64 ++++++
 tb/tb_msk_inv_mixcolumn_pipe.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/msk_aes_pkg.sv
// msk_aes_pkg: shared constants and share-layout helpers for the masked AES datapath.
package msk_aes_pkg;
    localparam logic [7:0] AES_POLY = 8'h1b;

    function automatic int col_w(input int d);
        return 32 * d;
    endfunction

    function automatic int byte_w(input int d);
        return 8 * d;
    endfunction

    // bit i of share j inside a masked byte
    function automatic int sh_idx(input int i, input int j, input int d);
        return i * d + j;
    endfunction
endpackage

// File: rtl/msk_inv_mixcolumn_pipe_if.sv
// msk_inv_mixcolumn_pipe_if: valid/ready column bus for the masked InvMixColumns pipe.
interface msk_inv_mixcolumn_pipe_if
    import msk_aes_pkg::*;
#(
    parameter int d = 2
);
    logic in_valid, in_ready, in_bypass, out_valid, out_ready, busy;
    logic [col_w(d)-1:0] sh_col_in, sh_col_out;

    modport master (
        output in_valid, in_bypass, sh_col_in, out_ready,
        input  in_ready, out_valid, sh_col_out, busy
    );
    modport slave (
        input  in_valid, in_bypass, sh_col_in, out_ready,
        output in_ready, out_valid, sh_col_out, busy
    );
endinterface

// File: rtl/msk_xtime_sharewise.sv
// msk_xtime_sharewise: multiplies each share of a masked byte by x in GF(2^8).
module msk_xtime_sharewise
    import msk_aes_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [byte_w(d)-1:0] x,
    output logic [byte_w(d)-1:0] y
);
    genvar i, j;
    for (j = 0; j < d; j++) begin : g_share
        assign y[sh_idx(0, j, d)] = x[sh_idx(7, j, d)];
        for (i = 1; i < 8; i++) begin : g_bit
            assign y[sh_idx(i, j, d)] = x[sh_idx(i - 1, j, d)] ^ (AES_POLY[i] & x[sh_idx(7, j, d)]);
        end
    end
endmodule

// File: rtl/msk_inv_mixcolumn_pipe.sv
// msk_inv_mixcolumn_pipe: two-stage sharewise InvMixColumns = MixColumns(P(col)) with bypass.
module msk_inv_mixcolumn_pipe
    import msk_aes_pkg::*;
#(
    parameter int d = 2
) (
    input logic clk,
    input logic rst_n,
    msk_inv_mixcolumn_pipe_if.slave bus
);
    localparam int BW = byte_w(d);
    localparam int CW = col_w(d);

    logic s1_valid, s1_bypass, s2_valid, s2_bypass, s1_load, s2_load;
    logic [CW-1:0] s1_data, s2_data, p_data, mc_data;
    logic [BW-1:0] a[4], b[4], t[4], uv_in[2], uv_mid[2], uv[2];

    assign s2_load      = !s2_valid | bus.out_ready;
    assign s1_load      = !s1_valid | s2_load;
    assign bus.in_ready = rst_n & s1_load;
    assign bus.out_valid = s2_valid;
    assign bus.busy     = s1_valid | s2_valid;
    assign bus.sh_col_out = s2_bypass ? s2_data : mc_data;

    assign uv_in[0] = a[0] ^ a[2];
    assign uv_in[1] = a[1] ^ a[3];

    genvar k;
    for (k = 0; k < 2; k++) begin : g_uv
        msk_xtime_sharewise #(.d(d)) u_x1 (.x(uv_in[k]),  .y(uv_mid[k]));
        msk_xtime_sharewise #(.d(d)) u_x2 (.x(uv_mid[k]), .y(uv[k]));
    end

    // byte-wise XOR of interleaved shares stays within each share
    for (k = 0; k < 4; k++) begin : g_row
        assign a[k] = s1_data[k*BW +: BW];
        assign b[k] = s2_data[k*BW +: BW];
        assign p_data[k*BW +: BW] = a[k] ^ uv[k % 2];
        msk_xtime_sharewise #(.d(d)) u_xt (.x(b[k]), .y(t[k]));
        assign mc_data[k*BW +: BW] = t[k] ^ t[(k + 1) % 4] ^ b[(k + 1) % 4] ^ b[(k + 2) % 4] ^ b[(k + 3) % 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
            s1_data   <= '0;
            s2_valid  <= 1'b0;
            s2_bypass <= 1'b0;
            s2_data   <= '0;
        end else begin
            if (s2_load) begin
                s2_valid  <= s1_valid;
                s2_bypass <= s1_bypass;
                s2_data   <= s1_bypass ? s1_data : p_data;
            end
            if (s1_load) begin
                s1_valid  <= bus.in_valid;
                s1_bypass <= bus.in_bypass;
                s1_data   <= bus.sh_col_in;
            end
        end
    end
endmodule

// File: tb/tb_msk_inv_mixcolumn_pipe.sv
// tb_msk_inv_mixcolumn_pipe: directed d=2 vectors plus a d=3 random stream against a GF(2^8) model.
module tb_msk_inv_mixcolumn_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msk_inv_mixcolumn_pipe_if #(.d(2)) a_if ();
    msk_inv_mixcolumn_pipe_if #(.d(3)) b_if ();
    msk_inv_mixcolumn_pipe #(.d(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    msk_inv_mixcolumn_pipe #(.d(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    int passed = 0;
    int total = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] im(input logic [31:0] w);
        logic [7:0] c[4];
        logic [31:0] o;
        for (int k = 0; k < 4; k++) c[k] = w[k*8 +: 8];
        for (int k = 0; k < 4; k++)
            o[k*8 +: 8] = gm(c[k], 8'h0e) ^ gm(c[(k+1)%4], 8'h0b) ^ gm(c[(k+2)%4], 8'h0d) ^ gm(c[(k+3)%4], 8'h09);
        return o;
    endfunction

    function automatic logic [95:0] pack(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2, input int d);
        logic [95:0] c = '0;
        logic [31:0] s;
        for (int j = 0; j < d; j++) begin
            s = (j == 0) ? s0 : (j == 1) ? s1 : s2;
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 8; i++) c[k*8*d + i*d + j] = s[k*8 + i];
        end
        return c;
    endfunction

    function automatic logic [31:0] unpack(input logic [95:0] c, input int d, input int j);
        logic [31:0] s;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) s[k*8 + i] = c[k*8*d + i*d + j];
        return s;
    endfunction

    function automatic logic [63:0] m2(input logic [31:0] v, input logic [31:0] r);
        logic [95:0] c = pack(r, v ^ r, 32'h0, 2);
        return c[63:0];
    endfunction

    function automatic logic [31:0] um2(input logic [63:0] c);
        return unpack({32'h0, c}, 2, 0) ^ unpack({32'h0, c}, 2, 1);
    endfunction

    localparam logic [31:0] KV_IN  = 32'hbca14d8e;
    localparam logic [31:0] KV_OUT = 32'h455313db;
    localparam logic [31:0] V1_IN  = 32'hd6d7d5d5;
    localparam logic [31:0] V1_OUT = 32'hd5d4d4d4;
    localparam logic [31:0] V2     = 32'h01010101;
    localparam logic [31:0] V3     = 32'hc6c6c6c6;

    logic [63:0] cb, snap;
    logic [95:0] exp_col;
    logic [95:0] q_sh[$];
    logic [31:0] q_v[$];
    logic [31:0] r0, r1, v;

    initial begin
        a_if.in_valid = 0; a_if.in_bypass = 0; a_if.sh_col_in = '0; a_if.out_ready = 1;
        b_if.in_valid = 0; b_if.in_bypass = 0; b_if.sh_col_in = '0; b_if.out_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 96'(a_if.out_valid), 96'(0));
        chk("rst_busy", 96'(a_if.busy), 96'(0));
        chk("rst_data", 96'(a_if.sh_col_out), 96'(0));
        chk("rst_in_ready", 96'(a_if.in_ready), 96'(0));
        rst_n = 1;

        // known vector, 2-cycle latency
        @(negedge clk);
        a_if.sh_col_in = m2(KV_IN, $urandom); a_if.in_valid = 1;
        #1 chk("kv_in_ready", 96'(a_if.in_ready), 96'(1));
        @(negedge clk);
        a_if.in_valid = 0;
        #1 chk("kv_not_yet", 96'(a_if.out_valid), 96'(0));
        @(negedge clk);
        #1 chk("kv_valid", 96'(a_if.out_valid), 96'(1));
        chk("kv_value", 96'(um2(a_if.sh_col_out)), 96'(KV_OUT));
        chk("kv_shares_differ", 96'(a_if.sh_col_out[63:32] != a_if.sh_col_out[31:0] ||
            unpack({32'h0, a_if.sh_col_out}, 2, 0) != unpack({32'h0, a_if.sh_col_out}, 2, 1)), 96'(1));
        @(negedge clk);
        #1 chk("kv_drop", 96'(a_if.out_valid), 96'(0));

        // back-to-back stream
        a_if.sh_col_in = m2(V1_IN, $urandom); a_if.in_valid = 1;
        @(negedge clk);
        a_if.sh_col_in = m2(V2, $urandom);
        @(negedge clk);
        a_if.sh_col_in = m2(V3, $urandom);
        #1 chk("st1_valid", 96'(a_if.out_valid), 96'(1));
        chk("st1_value", 96'(um2(a_if.sh_col_out)), 96'(V1_OUT));
        @(negedge clk);
        a_if.in_valid = 0;
        #1 chk("st2_valid", 96'(a_if.out_valid), 96'(1));
        chk("st2_value", 96'(um2(a_if.sh_col_out)), 96'(V2));
        @(negedge clk);
        #1 chk("st3_valid", 96'(a_if.out_valid), 96'(1));
        chk("st3_value", 96'(um2(a_if.sh_col_out)), 96'(V3));
        @(negedge clk);
        #1 chk("st_end", 96'(a_if.out_valid), 96'(0));

        // bypass
        cb = m2(KV_IN, $urandom);
        a_if.sh_col_in = cb; a_if.in_bypass = 1; a_if.in_valid = 1;
        @(negedge clk);
        a_if.in_valid = 0; a_if.in_bypass = 0;
        @(negedge clk);
        #1 chk("byp_valid", 96'(a_if.out_valid), 96'(1));
        chk("byp_exact", 96'(a_if.sh_col_out), 96'(cb));

        // backpressure
        @(negedge clk);
        a_if.out_ready = 0;
        a_if.sh_col_in = m2(V1_IN, $urandom); a_if.in_valid = 1;
        @(negedge clk);
        a_if.sh_col_in = m2(V2, $urandom);
        @(negedge clk);
        a_if.sh_col_in = m2(V3, $urandom);
        #1 chk("bp_in_ready", 96'(a_if.in_ready), 96'(0));
        chk("bp_valid", 96'(a_if.out_valid), 96'(1));
        snap = a_if.sh_col_out;
        @(negedge clk);
        #1 chk("bp_in_ready_hold", 96'(a_if.in_ready), 96'(0));
        chk("bp_stable", 96'(a_if.sh_col_out), 96'(snap));
        chk("bp_value1", 96'(um2(a_if.sh_col_out)), 96'(V1_OUT));
        a_if.out_ready = 1;
        #1 chk("bp_release_ready", 96'(a_if.in_ready), 96'(1));
        @(negedge clk);
        a_if.in_valid = 0;
        #1 chk("bp_value2", 96'(um2(a_if.sh_col_out)), 96'(V2));
        @(negedge clk);
        #1 chk("bp_valid3", 96'(a_if.out_valid), 96'(1));
        chk("bp_value3", 96'(um2(a_if.sh_col_out)), 96'(V3));
        @(negedge clk);
        #1 chk("bp_end", 96'(a_if.out_valid), 96'(0));

        // reset with both stages full
        a_if.out_ready = 0;
        a_if.sh_col_in = m2(KV_IN, $urandom); a_if.in_valid = 1;
        @(negedge clk);
        a_if.sh_col_in = m2(V1_IN, $urandom);
        @(negedge clk);
        a_if.in_valid = 0;
        #1 chk("mr_full_busy", 96'(a_if.busy), 96'(1));
        rst_n = 0;
        #1 chk("mr_in_ready_low", 96'(a_if.in_ready), 96'(0));
        @(negedge clk);
        #1 chk("mr_out_valid", 96'(a_if.out_valid), 96'(0));
        chk("mr_busy", 96'(a_if.busy), 96'(0));
        chk("mr_data", 96'(a_if.sh_col_out), 96'(0));
        rst_n = 1; a_if.out_ready = 1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1 chk("mr_no_ghost", 96'(a_if.out_valid), 96'(0));
        end

        // d=3 random stream, per-share golden model
        for (int c = 0; c < 1010; c++) begin
            @(negedge clk);
            #1;
            if (b_if.out_valid) begin
                if (q_sh.size() == 0) chk("d3_extra", 96'(1), 96'(0));
                else begin
                    exp_col = q_sh.pop_front();
                    v = q_v.pop_front();
                    chk("d3_shares", b_if.sh_col_out, exp_col);
                    chk("d3_value", 96'(unpack(b_if.sh_col_out, 3, 0) ^ unpack(b_if.sh_col_out, 3, 1) ^
                        unpack(b_if.sh_col_out, 3, 2)), 96'(im(v)));
                end
            end
            if (c < 1000) begin
                chk("d3_in_ready", 96'(b_if.in_ready), 96'(1));
                r0 = $urandom; r1 = $urandom; v = $urandom;
                b_if.sh_col_in = pack(r0, r1, v ^ r0 ^ r1, 3);
                b_if.in_valid = 1;
                q_sh.push_back(pack(im(r0), im(r1), im(v ^ r0 ^ r1), 3));
                q_v.push_back(v);
            end else b_if.in_valid = 0;
        end
        chk("d3_drained", 96'(q_sh.size()), 96'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
